uart_cmd_ctrl: RTL

Sequences the byte stream from uart_rx into register-write commands for the on-chip register file. Frame format: SYNC, ADDR, DATA and, with checksum enabled, CHK. Valid frames produce a single-cycle write strobe; malformed, errored or stalled frames are discarded and counted. Sits between uart_rx and the register bank.

---
 rtl/uart_cmd_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - turns uart_rx bytes (SYNC, ADDR, DATA[, CHK]) into register writes.
// Define CMD_CHECKSUM_EN to require a trailing CHK byte equal to SYNC ^ ADDR ^ DATA.
module uart_cmd_ctrl #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_ready,
  input  logic                 rx_error,
  input  logic [7:0]           rx_val,
  output logic                 wr_en,
  output logic [7:0]           wr_addr,
  output logic [7:0]           wr_data,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 timeout,
  output logic [CNT_WIDTH-1:0] frame_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

`ifdef CMD_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_CHK} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;
`endif

  state_t               state_q, state_d;
  logic                 ready_q;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic [7:0]           addr_q, addr_d, data_q, data_d;
  logic                 wr_en_q, wr_en_d, frame_err_q, frame_err_d, timeout_q, timeout_d;
  logic [7:0]           wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d, err_cnt_q, err_cnt_d;
  logic                 stb, commit, discard;

  assign stb = rx_ready & ~ready_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    wr_en_d     = 1'b0;
    frame_err_d = 1'b0;
    timeout_d   = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    commit      = 1'b0;
    discard     = 1'b0;
    tmo_d       = (stb || state_q == S_IDLE) ? '0 : tmo_q + TW'(1);

    if (stb) begin
      // A byte error inside a frame outranks any content check.
      if (state_q != S_IDLE && rx_error) begin
        discard = 1'b1;
      end else begin
        case (state_q)
          S_IDLE: if (!rx_error && rx_val == SYNC_BYTE) state_d = S_ADDR;
          S_ADDR: begin
            addr_d  = rx_val;
            state_d = S_DATA;
          end
          S_DATA: begin
            data_d = rx_val;
`ifdef CMD_CHECKSUM_EN
            state_d = S_CHK;
`else
            commit = 1'b1;
`endif
          end
`ifdef CMD_CHECKSUM_EN
          S_CHK: begin
            if (rx_val == (SYNC_BYTE ^ addr_q ^ data_q)) commit = 1'b1;
            else discard = 1'b1;
          end
`endif
          default: state_d = S_IDLE;
        endcase
      end
    end else if (state_q != S_IDLE && tmo_q == TMO_LAST) begin
      discard   = 1'b1;
      timeout_d = 1'b1;
      tmo_d     = '0;
    end

    if (commit) begin
      wr_en_d     = 1'b1;
      wr_addr_d   = addr_d;
      wr_data_d   = data_d;
      frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
      state_d     = S_IDLE;
    end
    if (discard) begin
      frame_err_d = 1'b1;
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b1;
      tmo_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      wr_en_q     <= 1'b0;
      frame_err_q <= 1'b0;
      timeout_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= rx_ready;
      tmo_q       <= tmo_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wr_en_q     <= wr_en_d;
      frame_err_q <= frame_err_d;
      timeout_q   <= timeout_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = (state_q != S_IDLE);
  assign frame_err = frame_err_q;
  assign timeout   = timeout_q;
  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule
